// File: rtl/usbf_sie_tx.sv
// USB SIE transmitter: sends a PID byte, then for data PIDs the payload and an on-the-fly CRC16, over UTMI.
// Optional: define USBF_SIE_TX_TURNAROUND_EN to enforce a bus turnaround delay after receive activity.
module usbf_sie_tx #(
    parameter int TURNAROUND_CYCLES = 16
) (
    input  logic       clk_i,
    input  logic       rstn_i,
    input  logic       enable_i,
    input  logic       tx_valid_i,
    input  logic [7:0] tx_pid_i,
    output logic       tx_accept_o,
    input  logic       data_valid_i,
    input  logic       data_strb_i,
    input  logic [7:0] data_i,
    input  logic       data_last_i,
    output logic       data_accept_o,
    output logic [7:0] utmi_data_o,
    output logic       utmi_txvalid_o,
    input  logic       utmi_txready_i,
    input  logic       utmi_rxactive_i,
    output logic       tx_active_o,
    output logic       tx_err_o
);

    // state | meaning
    // IDLE  | waiting for a packet request on a quiet bus
    // PID   | presenting the latched PID byte
    // DATA  | streaming payload bytes straight from data_i
    // CRC1  | presenting inverted CRC low byte
    // CRC2  | presenting inverted CRC high byte
    typedef enum logic [2:0] {ST_IDLE, ST_PID, ST_DATA, ST_CRC1, ST_CRC2} state_t;

    state_t      r_state;
    state_t      w_state_nxt;
    logic [7:0]  r_pid;
    logic [15:0] r_crc;
    logic        w_start_ok;
    logic        w_txvalid;
    logic [7:0]  w_data;
    logic        w_tx_accept;
    logic        w_data_accept;
    logic        w_tx_err;

    function automatic logic [15:0] f_crc16(input logic [15:0] crc_in, input logic [7:0] din);
        logic [15:0] c;
        c = crc_in;
        for (int i = 0; i < 8; i++) begin
            c = (c[0] ^ din[i]) ? ((c >> 1) ^ 16'hA001) : (c >> 1);
        end
        return c;
    endfunction

`ifdef USBF_SIE_TX_TURNAROUND_EN
    localparam int CW = $clog2(TURNAROUND_CYCLES + 1);
    logic [CW-1:0] r_ta_cnt;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_ta_cnt <= '0;
        end else if (utmi_rxactive_i) begin
            r_ta_cnt <= CW'(TURNAROUND_CYCLES);
        end else if (r_ta_cnt != '0) begin
            r_ta_cnt <= r_ta_cnt - CW'(1);
        end
    end

    assign w_start_ok = (r_ta_cnt == '0) && !utmi_rxactive_i;
`else
    logic w_unused_ta;
    assign w_unused_ta = (TURNAROUND_CYCLES != 0);
    assign w_start_ok  = !utmi_rxactive_i;
`endif

    always_comb begin
        w_state_nxt   = r_state;
        w_txvalid     = 1'b0;
        w_data        = 8'h00;
        w_tx_accept   = 1'b0;
        w_data_accept = 1'b0;
        w_tx_err      = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (tx_valid_i && w_start_ok) w_state_nxt = ST_PID;
            end
            ST_PID: begin
                w_txvalid = 1'b1;
                w_data    = r_pid;
                if (utmi_txready_i) begin
                    w_tx_accept = 1'b1;
                    w_state_nxt = (r_pid[1:0] == 2'b11) ? ST_DATA : ST_IDLE;
                end
            end
            ST_DATA: begin
                w_data    = data_i;
                w_txvalid = data_valid_i & data_strb_i;
                if (!data_valid_i) begin
                    // underrun: PHY closes the packet, host drops it on the bad CRC
                    w_tx_err    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_data_accept = utmi_txready_i | !data_strb_i;
                    if (w_data_accept && data_last_i) w_state_nxt = ST_CRC1;
                end
            end
            ST_CRC1: begin
                w_txvalid = 1'b1;
                w_data    = ~r_crc[7:0];
                if (utmi_txready_i) w_state_nxt = ST_CRC2;
            end
            ST_CRC2: begin
                w_txvalid = 1'b1;
                w_data    = ~r_crc[15:8];
                if (utmi_txready_i) w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
        if (!enable_i) begin
            w_state_nxt   = ST_IDLE;
            w_txvalid     = 1'b0;
            w_data        = 8'h00;
            w_tx_accept   = 1'b0;
            w_data_accept = 1'b0;
            w_tx_err      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state <= ST_IDLE;
            r_pid   <= 8'h00;
            r_crc   <= 16'hFFFF;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == ST_IDLE && w_state_nxt == ST_PID) r_pid <= tx_pid_i;
            if (w_state_nxt == ST_IDLE) begin
                r_crc <= 16'hFFFF;
            end else if (r_state == ST_DATA && w_txvalid && utmi_txready_i) begin
                r_crc <= f_crc16(r_crc, data_i);
            end
        end
    end

    assign utmi_data_o    = w_data;
    assign utmi_txvalid_o = w_txvalid;
    assign tx_accept_o    = w_tx_accept;
    assign data_accept_o  = w_data_accept;
    assign tx_err_o       = w_tx_err;
    assign tx_active_o    = (r_state != ST_IDLE);

endmodule

// File: tb/tb_usbf_sie_tx.sv
// Scoreboard bench for usbf_sie_tx: driver pushes expected UTMI bytes, a negedge monitor pops and compares.
module tb_usbf_sie_tx;

    logic       clk_i = 1'b0;
    logic       rstn_i;
    logic       enable_i;
    logic       tx_valid_i;
    logic [7:0] tx_pid_i;
    logic       tx_accept_o;
    logic       data_valid_i;
    logic       data_strb_i;
    logic [7:0] data_i;
    logic       data_last_i;
    logic       data_accept_o;
    logic [7:0] utmi_data_o;
    logic       utmi_txvalid_o;
    logic       utmi_txready_i;
    logic       utmi_rxactive_i;
    logic       tx_active_o;
    logic       tx_err_o;

    usbf_sie_tx #(.TURNAROUND_CYCLES(16)) dut (
        .clk_i(clk_i), .rstn_i(rstn_i), .enable_i(enable_i),
        .tx_valid_i(tx_valid_i), .tx_pid_i(tx_pid_i), .tx_accept_o(tx_accept_o),
        .data_valid_i(data_valid_i), .data_strb_i(data_strb_i), .data_i(data_i),
        .data_last_i(data_last_i), .data_accept_o(data_accept_o),
        .utmi_data_o(utmi_data_o), .utmi_txvalid_o(utmi_txvalid_o),
        .utmi_txready_i(utmi_txready_i), .utmi_rxactive_i(utmi_rxactive_i),
        .tx_active_o(tx_active_o), .tx_err_o(tx_err_o)
    );

    initial forever #5 clk_i = ~clk_i;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] obs_q[$];
    int xfer_cnt, tacc_cnt, dacc_cnt, err_cnt;
    logic [7:0] pay[16];
    logic       bp_pat[4] = '{1'b1, 1'b0, 1'b0, 1'b1};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic logic [15:0] crc_upd(input logic [15:0] c_in, input logic [7:0] d);
        logic [15:0] c;
        c = c_in;
        for (int i = 0; i < 8; i++) begin
            if (c[0] ^ d[i]) c = (c >> 1) ^ 16'hA001;
            else             c = c >> 1;
        end
        return c;
    endfunction

    // monitor
    initial begin
        logic       prev_stall;
        logic [7:0] prev_data;
        logic [7:0] e;
        prev_stall = 1'b0;
        prev_data  = 8'h00;
        forever begin
            @(negedge clk_i);
            if (rstn_i) begin
                if (utmi_txvalid_o && utmi_txready_i) begin
                    xfer_cnt++;
                    obs_q.push_back(utmi_data_o);
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL utmi_byte actual=%0h required=none", utmi_data_o);
                    end else begin
                        e = exp_q.pop_front();
                        chk("utmi_byte", {24'h0, utmi_data_o}, {24'h0, e});
                    end
                end
                if (prev_stall && utmi_txvalid_o)
                    chk("stall_hold", {24'h0, utmi_data_o}, {24'h0, prev_data});
                if (tx_accept_o || data_accept_o)
                    chk("accept_excl", {31'h0, tx_accept_o & data_accept_o}, 32'h0);
                prev_stall = utmi_txvalid_o && !utmi_txready_i;
                prev_data  = utmi_data_o;
                if (tx_accept_o)   tacc_cnt++;
                if (data_accept_o) dacc_cnt++;
                if (tx_err_o)      err_cnt++;
            end
        end
    end

    // abort_kind: 0 none, 1 underrun at payload index abort_at, 2 enable low at abort_at
    task automatic send_pkt(input logic [7:0] pid, input int n, input int abort_at,
                            input int abort_kind, input logic bp);
        int cyc;
        int idx;
        int presented;
        bit got;
        bit done;
        bit acc;
        logic [15:0] crc;
        xfer_cnt = 0; tacc_cnt = 0; dacc_cnt = 0; err_cnt = 0;
        obs_q.delete();
        crc = 16'hFFFF;
        exp_q.push_back(pid);
        tx_valid_i = 1'b1;
        tx_pid_i   = pid;
        cyc = 0;
        got = 1'b0;
        while (!got && cyc < 50) begin
            utmi_txready_i = bp ? bp_pat[cyc % 4] : 1'b1;
            @(negedge clk_i);
            got = tx_accept_o;
            @(posedge clk_i); #1;
            cyc++;
        end
        tx_valid_i = 1'b0;
        if (!got) chk("pid_timeout", 32'h0, 32'h1);
        if (got && pid[1:0] == 2'b11) begin
            idx = 0;
            presented = -1;
            done = 1'b0;
            while (!done && cyc < 300) begin
                utmi_txready_i = bp ? bp_pat[cyc % 4] : 1'b1;
                if (abort_kind == 1 && idx == abort_at) begin
                    data_valid_i = 1'b0;
                    @(negedge clk_i);
                    chk("underrun_txvalid", {31'h0, utmi_txvalid_o}, 32'h0);
                    chk("underrun_err", {31'h0, tx_err_o}, 32'h1);
                    @(posedge clk_i); #1;
                    chk("underrun_idle", {31'h0, tx_active_o}, 32'h0);
                    done = 1'b1;
                end else if (abort_kind == 2 && idx == abort_at) begin
                    data_valid_i   = 1'b1;
                    data_strb_i    = 1'b1;
                    data_i         = pay[idx];
                    data_last_i    = 1'b0;
                    utmi_txready_i = 1'b0;
                    enable_i       = 1'b0;
                    @(posedge clk_i); #1;
                    chk("disable_txvalid", {31'h0, utmi_txvalid_o}, 32'h0);
                    chk("disable_idle", {31'h0, tx_active_o}, 32'h0);
                    enable_i = 1'b1;
                    done = 1'b1;
                end else begin
                    data_valid_i = 1'b1;
                    data_strb_i  = (n != 0);
                    data_i       = (n != 0) ? pay[idx] : 8'h00;
                    data_last_i  = (n == 0) || (idx == n - 1);
                    if (n != 0 && idx != presented) begin
                        exp_q.push_back(pay[idx]);
                        crc = crc_upd(crc, pay[idx]);
                        presented = idx;
                    end
                    @(negedge clk_i);
                    acc = data_accept_o;
                    @(posedge clk_i); #1;
                    cyc++;
                    if (acc) begin
                        idx++;
                        if (n == 0 || idx == n) done = 1'b1;
                    end
                end
            end
            data_valid_i = 1'b0;
            data_strb_i  = 1'b0;
            data_last_i  = 1'b0;
            if (!done) chk("payload_timeout", 32'h0, 32'h1);
            if (abort_kind == 0) begin
                exp_q.push_back(~crc[7:0]);
                exp_q.push_back(~crc[15:8]);
            end
        end
        while (tx_active_o && cyc < 400) begin
            utmi_txready_i = bp ? bp_pat[cyc % 4] : 1'b1;
            @(posedge clk_i); #1;
            cyc++;
        end
        utmi_txready_i = 1'b1;
        chk("end_idle", {31'h0, tx_active_o}, 32'h0);
        @(posedge clk_i); #1;
        chk("drain", exp_q.size(), 32'h0);
    endtask

    function automatic logic [15:0] residual();
        logic [15:0] c;
        c = 16'hFFFF;
        for (int i = 1; i < obs_q.size(); i++) c = crc_upd(c, obs_q[i]);
        return c;
    endfunction

    initial begin
        int k;
        logic [7:0] setup[8] = '{8'h80, 8'h06, 8'h00, 8'h01, 8'h00, 8'h00, 8'h40, 8'h00};
        rstn_i = 1'b0; enable_i = 1'b1; tx_valid_i = 1'b0; tx_pid_i = 8'h00;
        data_valid_i = 1'b0; data_strb_i = 1'b0; data_i = 8'h00; data_last_i = 1'b0;
        utmi_txready_i = 1'b1; utmi_rxactive_i = 1'b0;
        for (int i = 0; i < 16; i++) pay[i] = 8'h00;
        repeat (3) @(posedge clk_i);
        #1 rstn_i = 1'b1;
        @(negedge clk_i);
        chk("rst_txvalid", {31'h0, utmi_txvalid_o}, 32'h0);
        chk("rst_data", {24'h0, utmi_data_o}, 32'h0);
        chk("rst_active", {31'h0, tx_active_o}, 32'h0);
        chk("rst_accepts", {30'h0, tx_accept_o, data_accept_o}, 32'h0);
        chk("rst_err", {31'h0, tx_err_o}, 32'h0);
        @(posedge clk_i); #1;

        send_pkt(8'hD2, 0, 0, 0, 1'b0);
        chk("ack_xfers", xfer_cnt, 1);
        chk("ack_txacc", tacc_cnt, 1);
        chk("ack_dacc", dacc_cnt, 0);

        send_pkt(8'h4B, 0, 0, 0, 1'b0);
        chk("zlp_xfers", xfer_cnt, 3);
        chk("zlp_dacc", dacc_cnt, 1);
        chk("zlp_residual", {16'h0, residual()}, 32'hB001);

        for (int i = 0; i < 8; i++) pay[i] = setup[i];
        send_pkt(8'hC3, 8, 0, 0, 1'b0);
        chk("setup_xfers", xfer_cnt, 11);
        chk("setup_dacc", dacc_cnt, 8);
        chk("setup_txacc", tacc_cnt, 1);
        chk("setup_residual", {16'h0, residual()}, 32'hB001);

        send_pkt(8'hC3, 8, 0, 0, 1'b1);
        chk("bp_xfers", xfer_cnt, 11);
        chk("bp_dacc", dacc_cnt, 8);
        chk("bp_residual", {16'h0, residual()}, 32'hB001);

        pay[0] = 8'hA5; pay[1] = 8'h3C; pay[2] = 8'h77; pay[3] = 8'h18;
        send_pkt(8'h4B, 4, 2, 1, 1'b0);
        chk("underrun_xfers", xfer_cnt, 3);
        chk("underrun_errcnt", err_cnt, 1);

        pay[0] = 8'h01; pay[1] = 8'h02;
        send_pkt(8'h87, 2, 0, 0, 1'b0);
        chk("after_underrun_residual", {16'h0, residual()}, 32'hB001);
        chk("after_underrun_xfers", xfer_cnt, 5);

        for (int i = 0; i < 8; i++) pay[i] = setup[i];
        send_pkt(8'hC3, 8, 3, 2, 1'b0);
        chk("disable_xfers", xfer_cnt, 4);
        chk("disable_errcnt", err_cnt, 0);

        // request held off by receive activity, then turnaround timing
        utmi_rxactive_i = 1'b1;
        tx_valid_i = 1'b1;
        tx_pid_i   = 8'h5A;
        exp_q.push_back(8'h5A);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk("rx_wait_txvalid", {31'h0, utmi_txvalid_o}, 32'h0);
            @(posedge clk_i); #1;
        end
        utmi_rxactive_i = 1'b0;
        k = 0;
        while (k < 40) begin
            @(negedge clk_i);
            if (utmi_txvalid_o) break;
            @(posedge clk_i); #1;
            k++;
        end
        @(posedge clk_i); #1;
        tx_valid_i = 1'b0;
`ifdef USBF_SIE_TX_TURNAROUND_EN
        chk("turnaround_delay", k, 17);
`else
        chk("turnaround_delay", k, 1);
`endif
        repeat (2) @(posedge clk_i);
        #1;
        chk("turnaround_drain", exp_q.size(), 32'h0);
        chk("turnaround_idle", {31'h0, tx_active_o}, 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
